// File: rtl/conv_pkg.sv
// Shared types and helpers for the multi-lane convolution engine.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_KER,
        ST_LOAD_WIN,
        ST_MAC,
        ST_OUT
    } conv_state_e;

    localparam int KSIZE_DEF = 3;
    localparam int KK_DEF    = KSIZE_DEF * KSIZE_DEF;

    function automatic int kk_of(input int ksize);
        return ksize * ksize;
    endfunction

    // Arithmetic shift, optional ReLU, then clamp into a signed out_w-bit range.
    function automatic logic signed [63:0] requant(input logic signed [63:0] acc,
                                                   input logic [4:0]         shift,
                                                   input logic               relu,
                                                   input int                 out_w);
        logic signed [63:0] y;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        y  = acc >>> shift;
        if (relu && (y < 0)) y = '0;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (y > hi) y = hi;
        else if (y < lo) y = lo;
        return y;
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One output lane: window buffer, multiply-accumulate and requantised result register.
module conv_mac_lane
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int KK     = 9,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 8,
    parameter int IDX_W  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     acc_clr,
    input  logic                     mac_en,
    input  logic [IDX_W-1:0]         mac_idx,
    input  logic signed [DATA_W-1:0] ker,
    input  logic                     out_en,
    input  logic [4:0]               shift,
    input  logic                     relu,
    output logic [OUT_W-1:0]         sum
);

    logic signed [DATA_W-1:0]   win [KK];
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;
    logic signed [63:0]         rq;

    assign prod = win[mac_idx] * ker;
    assign rq   = requant({{(64-ACC_W){acc[ACC_W-1]}}, acc}, shift, relu, OUT_W);

    always_ff @(posedge i_clk) begin
        if (wr_en) win[wr_idx] <= wr_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc <= '0;
            sum <= '0;
        end else begin
            if (acc_clr)     acc <= '0;
            else if (mac_en) acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
            if (out_en)      sum <= rq[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/conv_engine_multilane.sv
// KSIZE x KSIZE convolution over LANES strided windows: sequencing FSM, kernel buffer, address generation.
//   state       | meaning
//   ST_IDLE     | waiting for i_start, config latched on start
//   ST_LOAD_KER | KK+1 cycles: issue kernel reads, capture one cycle later
//   ST_LOAD_WIN | KK+1 cycles: issue per-lane window reads, capture one cycle later
//   ST_MAC      | KK cycles: one product per lane per cycle
//   ST_OUT      | requantise into o_sum; o_valid/o_done follow next cycle
module conv_engine_multilane
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int KSIZE  = 3,
    parameter int IMG_W  = 28,
    parameter int ADDR_W = 10,
    parameter int LANES  = 2,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_reuse_ker,
    input  logic [ADDR_W-1:0]         i_src_base,
    input  logic [ADDR_W-1:0]         i_ker_base,
    input  logic [2:0]                i_stride,
    input  logic [4:0]                i_shift,
    input  logic                      i_relu,
    output logic [ADDR_W-1:0]         o_ker_addr,
    input  logic [DATA_W-1:0]         i_ker_data,
    output logic [LANES*ADDR_W-1:0]   o_src_addr,
    input  logic [LANES*DATA_W-1:0]   i_src_data,
    output logic [LANES*OUT_W-1:0]    o_sum,
    output logic                      o_valid,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int KK    = kk_of(KSIZE);
    localparam int CNT_W = $clog2(KK + 1);
    localparam int IDX_W = $clog2(KK);

    conv_state_e state, state_nxt;

    logic [CNT_W-1:0]         cnt;
    logic [2:0]               row, col;
    logic                     ker_valid;
    logic [ADDR_W-1:0]        src_base_q, ker_base_q;
    logic [2:0]               stride_q;
    logic [4:0]               shift_q;
    logic                     relu_q;
    logic signed [DATA_W-1:0] kernel [KK];

    logic                     last_ld;
    logic [IDX_W-1:0]         cap_idx;
    logic [IDX_W-1:0]         cur_idx;
    logic [ADDR_W-1:0]        row_off;

    assign last_ld = (cnt == CNT_W'(KK));
    assign cap_idx = IDX_W'(cnt - CNT_W'(1));
    assign cur_idx = IDX_W'(cnt);
    assign row_off = ADDR_W'(32'(row) * IMG_W + 32'(col));
    assign o_busy  = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (i_start) state_nxt = (i_reuse_ker && ker_valid) ? ST_LOAD_WIN : ST_LOAD_KER;
            ST_LOAD_KER: if (last_ld) state_nxt = ST_LOAD_WIN;
            ST_LOAD_WIN: if (last_ld) state_nxt = ST_MAC;
            ST_MAC:      if (cnt == CNT_W'(KK - 1)) state_nxt = ST_OUT;
            ST_OUT:      state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            row        <= '0;
            col        <= '0;
            ker_valid  <= 1'b0;
            src_base_q <= '0;
            ker_base_q <= '0;
            stride_q   <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            o_valid    <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state <= state_nxt;
            // Row/column walk restarts on every state change so each phase scans row-major from (0,0).
            if (state_nxt != state) begin
                cnt <= '0;
                row <= '0;
                col <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (col == 3'(KSIZE - 1)) begin
                    col <= '0;
                    row <= row + 3'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end
            if (state == ST_IDLE && i_start) begin
                src_base_q <= i_src_base;
                ker_base_q <= i_ker_base;
                stride_q   <= i_stride;
                shift_q    <= i_shift;
                relu_q     <= i_relu;
            end
            if (state == ST_LOAD_KER && last_ld) ker_valid <= 1'b1;
            o_valid <= (state == ST_OUT);
            o_done  <= (state == ST_OUT);
        end
    end

    always_ff @(posedge i_clk) begin
        if (state == ST_LOAD_KER && cnt != '0) kernel[cap_idx] <= i_ker_data;
    end

    assign o_ker_addr = (state == ST_LOAD_KER && !last_ld) ? ker_base_q + ADDR_W'(cnt) : '0;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [ADDR_W-1:0] lane_off;
        assign lane_off = ADDR_W'(l) * ADDR_W'(stride_q);
        assign o_src_addr[l*ADDR_W +: ADDR_W] =
            (state == ST_LOAD_WIN && !last_ld) ? src_base_q + lane_off + row_off : '0;

        conv_mac_lane #(
            .DATA_W (DATA_W),
            .KK     (KK),
            .ACC_W  (ACC_W),
            .OUT_W  (OUT_W),
            .IDX_W  (IDX_W)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .wr_en   (state == ST_LOAD_WIN && cnt != '0),
            .wr_idx  (cap_idx),
            .wr_data (i_src_data[l*DATA_W +: DATA_W]),
            .acc_clr (state == ST_LOAD_WIN && last_ld),
            .mac_en  (state == ST_MAC),
            .mac_idx (cur_idx),
            .ker     (kernel[cur_idx]),
            .out_en  (state == ST_OUT),
            .shift   (shift_q),
            .relu    (relu_q),
            .sum     (o_sum[l*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_conv_engine_multilane.sv
// Randomised bench for conv_engine_multilane against a plain-arithmetic convolution model.
module tb_conv_engine_multilane;

    localparam int DATA_W = 8;
    localparam int KSIZE  = 3;
    localparam int IMG_W  = 28;
    localparam int ADDR_W = 10;
    localparam int LANES  = 2;
    localparam int ACC_W  = 20;
    localparam int OUT_W  = 8;
    localparam int MEM_N  = 1 << ADDR_W;
    localparam int KKN    = KSIZE * KSIZE;

    logic                    i_clk, i_rst, i_start, i_reuse_ker, i_relu;
    logic [ADDR_W-1:0]       i_src_base, i_ker_base, o_ker_addr;
    logic [2:0]              i_stride;
    logic [4:0]              i_shift;
    logic [DATA_W-1:0]       i_ker_data;
    logic [LANES*ADDR_W-1:0] o_src_addr;
    logic [LANES*DATA_W-1:0] i_src_data;
    logic [LANES*OUT_W-1:0]  o_sum;
    logic                    o_valid, o_busy, o_done;

    conv_engine_multilane #(
        .DATA_W(DATA_W), .KSIZE(KSIZE), .IMG_W(IMG_W), .ADDR_W(ADDR_W),
        .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_reuse_ker(i_reuse_ker),
        .i_src_base(i_src_base), .i_ker_base(i_ker_base), .i_stride(i_stride),
        .i_shift(i_shift), .i_relu(i_relu), .o_ker_addr(o_ker_addr), .i_ker_data(i_ker_data),
        .o_src_addr(o_src_addr), .i_src_data(i_src_data), .o_sum(o_sum),
        .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic signed [DATA_W-1:0] ker_mem [MEM_N];
    logic signed [DATA_W-1:0] src_mem [MEM_N];

    always @(posedge i_clk) begin
        i_ker_data <= ker_mem[o_ker_addr];
        for (int l = 0; l < LANES; l++)
            i_src_data[l*DATA_W +: DATA_W] <= src_mem[o_src_addr[l*ADDR_W +: ADDR_W]];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    int mdl_ker [KKN];
    bit mdl_kv = 1'b0;
    int exp_sum [LANES];

    task automatic model_job(input bit reuse, input int sb, input int kb, input int st,
                             input int sh, input bit relu, output int lat);
        int acc, y, lo, hi;
        if (reuse && mdl_kv) begin
            lat = 2 * KKN + 2;
        end else begin
            for (int k = 0; k < KKN; k++) mdl_ker[k] = int'(ker_mem[(kb + k) % MEM_N]);
            mdl_kv = 1'b1;
            lat = 3 * KKN + 3;
        end
        hi = (1 << (OUT_W - 1)) - 1;
        lo = -(1 << (OUT_W - 1));
        for (int l = 0; l < LANES; l++) begin
            acc = 0;
            for (int r = 0; r < KSIZE; r++)
                for (int c = 0; c < KSIZE; c++)
                    acc += mdl_ker[r*KSIZE + c] * int'(src_mem[(sb + l*st + r*IMG_W + c) % MEM_N]);
            y = acc >>> sh;
            if (relu && y < 0) y = 0;
            if (y > hi) y = hi;
            if (y < lo) y = lo;
            exp_sum[l] = y;
        end
    endtask

    function automatic int lane_sum(input int l);
        logic signed [OUT_W-1:0] v;
        v = o_sum[l*OUT_W +: OUT_W];
        return int'(v);
    endfunction

    task automatic run_job(input bit reuse, input int sb, input int kb, input int st,
                           input int sh, input bit relu, input bit poke, input string tag);
        int lat, n, kchg, extra;
        bit seen;
        logic [ADDR_W-1:0] ka0;
        model_job(reuse, sb, kb, st, sh, relu, lat);
        @(negedge i_clk);
        i_start     = 1'b1;
        i_reuse_ker = reuse;
        i_src_base  = ADDR_W'(sb);
        i_ker_base  = ADDR_W'(kb);
        i_stride    = 3'(st);
        i_shift     = 5'(sh);
        i_relu      = relu;
        @(negedge i_clk);
        i_start    = 1'b0;
        i_src_base = ADDR_W'($urandom);
        i_ker_base = ADDR_W'($urandom);
        i_stride   = 3'($urandom);
        i_shift    = 5'($urandom);
        i_relu     = 1'($urandom);
        n = 0; seen = 1'b0; kchg = 0; ka0 = o_ker_addr;
        while (!seen && n < 100) begin
            if (n == lat - 20) begin
                chk({tag, "_addr0"}, int'(o_src_addr[ADDR_W-1:0]), sb % MEM_N);
                chk({tag, "_addr1"}, int'(o_src_addr[2*ADDR_W-1:ADDR_W]), (sb + st) % MEM_N);
            end
            if (n == 5) chk({tag, "_busy"}, int'(o_busy), 1);
            if (poke && n == 15) i_start = 1'b1;
            if (poke && n == 16) i_start = 1'b0;
            if (o_ker_addr !== ka0) kchg++;
            if (o_done === 1'b1) seen = 1'b1;
            else begin
                @(negedge i_clk);
                n++;
            end
        end
        chk({tag, "_latency"}, n, lat);
        if (seen) begin
            chk({tag, "_valid"}, int'(o_valid), 1);
            for (int l = 0; l < LANES; l++) chk($sformatf("%s_lane%0d", tag, l), lane_sum(l), exp_sum[l]);
            if (lat == 2 * KKN + 2) chk({tag, "_keraddr_moves"}, kchg, 0);
        end
        extra = 0;
        repeat (4) begin
            @(negedge i_clk);
            if (o_done === 1'b1) extra++;
        end
        chk({tag, "_extra_done"}, extra, 0);
        chk({tag, "_idle"}, int'(o_busy), 0);
    endtask

    task automatic fill_const(input bit to_ker, input int v);
        for (int a = 0; a < MEM_N; a++) begin
            if (to_ker) ker_mem[a] = DATA_W'(v);
            else        src_mem[a] = DATA_W'(v);
        end
    endtask

    task automatic fill_rand(input bit to_ker);
        for (int a = 0; a < MEM_N; a++) begin
            if (to_ker) ker_mem[a] = DATA_W'($urandom);
            else        src_mem[a] = DATA_W'($urandom);
        end
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_reuse_ker = 1'b0; i_relu = 1'b0;
        i_src_base = '0; i_ker_base = '0; i_stride = '0; i_shift = '0;
        fill_const(1'b1, 0);
        fill_const(1'b0, 0);
        repeat (3) @(negedge i_clk);
        chk("rst_sum", int'(o_sum), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_keraddr", int'(o_ker_addr), 0);
        chk("rst_srcaddr", int'(o_src_addr), 0);
        i_rst = 1'b0;

        // Reuse requested with no kernel loaded yet must take the full path.
        fill_const(1'b1, 1);
        fill_const(1'b0, 2);
        run_job(1'b1, 0, 0, 1, 0, 1'b0, 1'b0, "ones");
        chk("ones_l0_const", lane_sum(0), 18);
        chk("ones_l1_const", lane_sum(1), 18);

        fill_const(1'b1, 0);
        ker_mem[4] = 8'sd1;
        for (int a = 0; a < MEM_N; a++) src_mem[a] = DATA_W'(a % 128);
        run_job(1'b0, 0, 0, 3, 0, 1'b0, 1'b0, "ident");
        chk("ident_l0_const", lane_sum(0), 29);
        chk("ident_l1_const", lane_sum(1), 32);

        fill_const(1'b1, 127);
        fill_const(1'b0, 127);
        run_job(1'b0, 0, 0, 1, 0, 1'b0, 1'b0, "satpos");
        chk("satpos_const", lane_sum(0), 127);
        fill_const(1'b1, -1);
        run_job(1'b0, 0, 0, 1, 0, 1'b0, 1'b0, "satneg");
        chk("satneg_const", lane_sum(0), -128);
        // Stored kernel (-1) must be used even though memory now holds 5.
        fill_const(1'b1, 5);
        run_job(1'b1, 0, 0, 1, 0, 1'b1, 1'b0, "reuse_relu");
        chk("reuse_relu_const", lane_sum(1), 0);

        fill_rand(1'b1);
        fill_rand(1'b0);
        run_job(1'b0, 100, 40, 5, 6, 1'b0, 1'b1, "poke");

        i_start = 1'b1; i_reuse_ker = 1'b0; i_src_base = '0; i_ker_base = '0;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (22) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("midrst_busy", int'(o_busy), 0);
        chk("midrst_sum", int'(o_sum), 0);
        chk("midrst_valid", int'(o_valid), 0);
        mdl_kv = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        run_job(1'b1, 200, 7, 2, 5, 1'b0, 1'b0, "postrst");

        run_job(1'b0, 1020, 1020, 2, 5, 1'b0, 1'b0, "wrap");

        run_job(1'b1, 333, 0, 0, 4, 1'b1, 1'b0, "stride0");
        chk("stride0_equal", lane_sum(1), lane_sum(0));

        for (int j = 0; j < 10; j++) begin
            bit reuse;
            reuse = 1'($urandom);
            if (!reuse) fill_rand(1'b1);
            fill_rand(1'b0);
            run_job(reuse, int'($urandom_range(0, MEM_N - 1)), int'($urandom_range(0, MEM_N - 1)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 12)), 1'($urandom),
                    1'($urandom), $sformatf("rnd%0d", j));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
